// File: rtl/sdrd_deserializer.sv
// sdrd_deserializer: samples the serial-read sequencer's SDRD line while the read
// window is open, assembles WIDTH-bit words and presents them to the host with a
// valid/ack handshake. Also flags overruns and partial words dropped on an idle timeout.
module sdrd_deserializer #(
    parameter int WIDTH        = 8,
    parameter int MSB_FIRST    = 1,
    parameter int IDLE_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sser_n,
    input  logic             ba13,
    input  logic             ba12,
    input  logic             br_w,
    input  logic             sdrd_oe,
    input  logic             sdrd,
    input  logic             rd_ack,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             ovr_o,
    output logic             abort_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDL_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [IDL_W-1:0] LAST_IDL = IDL_W'(IDLE_TIMEOUT - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDL_W-1:0]   r_idle;
    logic [IDL_W-1:0]   w_idle_nxt;
    logic [WIDTH-1:0]   r_sh;
    logic [WIDTH-1:0]   w_sh_nxt;
    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_ovr;
    logic               r_abort;
    logic               w_bit_en;
    logic               w_done;
    logic               w_timeout;

    assign w_bit_en = ~sser_n & ~ba13 & ba12 & br_w & sdrd_oe;

    // Shift register with the current sdrd bit inserted at the configured end
    always_comb begin
        if (MSB_FIRST != 0) begin
            w_shifted = {r_sh[WIDTH-2:0], sdrd};
        end else begin
            w_shifted = {sdrd, r_sh[WIDTH-1:1]};
        end
    end

    // Next-state logic: bit assembly, word completion and idle timeout
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idle_nxt  = r_idle;
        w_sh_nxt    = r_sh;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_bit_en) begin
                    w_sh_nxt    = w_shifted;
                    w_cnt_nxt   = CNT_W'(1);
                    w_idle_nxt  = '0;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_bit_en) begin
                    w_idle_nxt = '0;
                    if (r_cnt == LAST_CNT) begin
                        // Last bit: the full word goes straight to data_o
                        w_done      = 1'b1;
                        w_sh_nxt    = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_sh_nxt  = w_shifted;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else if (r_idle == LAST_IDL) begin
                    // Window gap too long: drop the partial word
                    w_timeout   = 1'b1;
                    w_sh_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_idle_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idle_nxt = r_idle + IDL_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_idle_nxt  = '0;
                w_sh_nxt    = '0;
            end
        endcase
    end

    // State, counters and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idle  <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idle  <= w_idle_nxt;
            r_sh    <= w_sh_nxt;
        end
    end

    // Host-side word holding register and handshake/sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            if (w_done) begin
                r_data <= w_shifted;
            end
            if (w_done) begin
                r_valid <= 1'b1;
            end else if (rd_ack) begin
                r_valid <= 1'b0;
            end
            // An ack in the completion cycle consumes the old word, so nothing is lost
            if (w_done && r_valid && !rd_ack) begin
                r_ovr <= 1'b1;
            end else if (rd_ack) begin
                r_ovr <= 1'b0;
            end
            // A timeout in the same cycle as an ack is a new event and wins
            if (w_timeout) begin
                r_abort <= 1'b1;
            end else if (rd_ack) begin
                r_abort <= 1'b0;
            end
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign ovr_o   = r_ovr;
    assign abort_o = r_abort;
    assign busy_o  = (r_state == S_SHIFT);

endmodule

// File: tb/tb_sdrd_deserializer.sv
// Testbench for sdrd_deserializer: an MSB-first and an LSB-first instance share all
// inputs; a queue-based model of the word assembly is checked on every clock, with
// extra directed checks at the interesting points.
module tb_sdrd_deserializer;

    localparam int W  = 8;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst, sser_n, ba13, ba12, br_w, sdrd_oe, sdrd, rd_ack;
    logic [W-1:0] data_m, data_l;
    logic valid_m, ovr_m, abort_m, busy_m;
    logic valid_l, ovr_l, abort_l, busy_l;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          q[$];
    int          gap;
    logic [W-1:0] md_m, md_l;
    logic        mv, mo, ma;

    always #5 clk = ~clk;

    sdrd_deserializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_TIMEOUT(TO)) dut_m (
        .clk(clk), .rst(rst), .sser_n(sser_n), .ba13(ba13), .ba12(ba12), .br_w(br_w),
        .sdrd_oe(sdrd_oe), .sdrd(sdrd), .rd_ack(rd_ack), .data_o(data_m),
        .valid_o(valid_m), .ovr_o(ovr_m), .abort_o(abort_m), .busy_o(busy_m));

    sdrd_deserializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_TIMEOUT(TO)) dut_l (
        .clk(clk), .rst(rst), .sser_n(sser_n), .ba13(ba13), .ba12(ba12), .br_w(br_w),
        .sdrd_oe(sdrd_oe), .sdrd(sdrd), .rd_ack(rd_ack), .data_o(data_l),
        .valid_o(valid_l), .ovr_o(ovr_l), .abort_o(abort_l), .busy_o(busy_l));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model update for one rising edge, from the rules for words, timeouts and acks
    task automatic model_edge();
        bit en, done, tmo, nv, no, na;
        if (rst) begin
            q.delete(); gap = 0;
            md_m = '0; md_l = '0; mv = 0; mo = 0; ma = 0;
            return;
        end
        en   = !sser_n && !ba13 && ba12 && br_w && sdrd_oe;
        done = 0;
        tmo  = 0;
        if (en) begin
            q.push_back(int'(sdrd));
            gap = 0;
            if (q.size() == W) begin
                done = 1;
                md_m = '0;
                md_l = '0;
                for (int i = 0; i < W; i++) begin
                    md_m = md_m + W'(q[i] * (1 << (W - 1 - i)));
                    md_l = md_l + W'(q[i] * (1 << i));
                end
                q.delete();
            end
        end else if (q.size() > 0) begin
            gap++;
            if (gap == TO) begin
                tmo = 1;
                q.delete();
                gap = 0;
            end
        end
        nv = done ? 1'b1 : (rd_ack ? 1'b0 : mv);
        no = (done && mv && !rd_ack) ? 1'b1 : (rd_ack ? 1'b0 : mo);
        na = tmo ? 1'b1 : (rd_ack ? 1'b0 : ma);
        mv = nv; mo = no; ma = na;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("data_msb",  data_m,  md_m);
        chk("data_lsb",  data_l,  md_l);
        chk("valid_msb", valid_m, mv);
        chk("valid_lsb", valid_l, mv);
        chk("ovr",       ovr_m,   mo);
        chk("abort",     abort_m, ma);
        chk("busy_msb",  busy_m,  (q.size() > 0));
        chk("busy_lsb",  busy_l,  (q.size() > 0));
    endtask

    task automatic win(input logic en);
        sser_n = !en; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1; sdrd_oe = 1'b1;
    endtask

    // Send n bits taken from b, starting at b[7]; optional ack on the last bit
    task automatic send(input logic [7:0] b, input int n, input logic ack_last);
        for (int i = 0; i < n; i++) begin
            rst = 1'b0; win(1'b1); sdrd = b[7-i];
            rd_ack = ack_last && (i == n - 1);
            tick();
        end
        rd_ack = 1'b0;
    endtask

    task automatic gapc(input int n, input logic ack_last);
        for (int i = 0; i < n; i++) begin
            rst = 1'b0; win(1'b0); sdrd = 1'b1;
            rd_ack = ack_last && (i == n - 1);
            tick();
        end
        rd_ack = 1'b0;
    endtask

    initial begin
        int p;
        int probs [3] = '{90, 40, 5};
        q.delete(); gap = 0; md_m = '0; md_l = '0; mv = 0; mo = 0; ma = 0;
        rst = 1'b1; win(1'b1); sdrd = 1'b1; rd_ack = 1'b0;
        tick();
        tick();
        chk("rst_data",  data_m,  8'h00);
        chk("rst_valid", valid_m, 1'b0);
        chk("rst_busy",  busy_m,  1'b0);
        rst = 1'b0;

        // Test 1: MSB-first A5, busy during bits 1..7
        for (int i = 0; i < 8; i++) begin
            logic [7:0] pat;
            pat = 8'hA5;
            win(1'b1); sdrd = pat[7-i]; rd_ack = 1'b0;
            tick();
            chk("t1_busy", busy_m, (i < 7));
            chk("t1_valid_pending", valid_m, (i == 7));
        end
        chk("t1_data", data_m, 8'hA5);
        gapc(1, 1'b1);
        chk("t1_ack_valid", valid_m, 1'b0);
        chk("t1_ack_data",  data_m,  8'hA5);

        // Test 2: LSB-first ordering
        send(8'hC0, 8, 1'b0);
        chk("t2_lsb", data_l, 8'h03);
        chk("t2_msb", data_m, 8'hC0);
        gapc(1, 1'b1);

        // Test 3: overrun
        send(8'h3C, 8, 1'b0);
        send(8'hC3, 8, 1'b0);
        chk("t3_data", data_m, 8'hC3);
        chk("t3_ovr",  ovr_m,  1'b1);
        chk("t3_valid", valid_m, 1'b1);
        gapc(1, 1'b1);
        chk("t3_ack_ovr",   ovr_m,   1'b0);
        chk("t3_ack_valid", valid_m, 1'b0);

        // Test 4: timeout at the 15th idle edge, and a gap of 14 survives
        send(8'hF0, 4, 1'b0);
        gapc(14, 1'b0);
        chk("t4_busy14",  busy_m,  1'b1);
        chk("t4_abort14", abort_m, 1'b0);
        gapc(1, 1'b0);
        chk("t4_abort15", abort_m, 1'b1);
        chk("t4_busy15",  busy_m,  1'b0);
        gapc(1, 1'b1);
        chk("t4_abort_clr", abort_m, 1'b0);
        send(8'hA0, 4, 1'b0);
        gapc(14, 1'b0);
        send(8'h50, 4, 1'b0);
        chk("t4_word",  data_m,  8'hA5);
        chk("t4_noabt", abort_m, 1'b0);
        chk("t4_valid", valid_m, 1'b1);

        // Test 5: completion coincides with ack of the previous word
        send(8'h81, 8, 1'b1);
        chk("t5_valid", valid_m, 1'b1);
        chk("t5_ovr",   ovr_m,   1'b0);
        chk("t5_data",  data_m,  8'h81);
        // Timeout together with ack: abort wins, valid clears
        send(8'hC0, 2, 1'b0);
        gapc(15, 1'b1);
        chk("t5_tmo_abort", abort_m, 1'b1);
        chk("t5_tmo_valid", valid_m, 1'b0);

        // Test 6: reset mid-word
        send(8'hFF, 5, 1'b0);
        rst = 1'b1; win(1'b1); sdrd = 1'b1; rd_ack = 1'b0;
        tick();
        rst = 1'b0;
        chk("t6_rst_busy",  busy_m,  1'b0);
        chk("t6_rst_abort", abort_m, 1'b0);
        chk("t6_rst_data",  data_m,  8'h00);
        send(8'h5A, 8, 1'b0);
        chk("t6_data",  data_m,  8'h5A);
        chk("t6_valid", valid_m, 1'b1);
        chk("t6_ovr",   ovr_m,   1'b0);

        // Randomized phases with varying window density
        for (int n = 0; n < 3000; n++) begin
            p = probs[(n / 250) % 3];
            rst = ($urandom_range(0, 599) == 0);
            win(1'b1);
            if ($urandom_range(0, 99) >= p) begin
                case ($urandom_range(0, 4))
                    0:       sser_n  = 1'b1;
                    1:       ba13    = 1'b1;
                    2:       ba12    = 1'b0;
                    3:       br_w    = 1'b0;
                    default: sdrd_oe = 1'b0;
                endcase
            end
            sdrd   = 1'($urandom);
            rd_ack = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
